// File: rtl/i2c_frame_master.sv
// i2c_frame_master: I2C master bit/frame engine running START, WRITE, READ and STOP.
// Each bit or condition takes four phases of clock_divisor+1 cycles; SCL stretching can be honoured.
module i2c_frame_master #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAME_BITS = 8,
    parameter bit STRETCH_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  clock_divisor,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [FRAME_BITS-1:0] cmd_data,
    input  logic                  cmd_nack,
    output logic                  rsp_valid,
    output logic [FRAME_BITS-1:0] rsp_data,
    output logic                  rsp_nack,
    output logic                  rsp_err,
    output logic                  scl_out,
    output logic                  sda_out,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  busy
);
    localparam int BW = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLD} state_t;

    state_t                state, state_n;
    logic [DIV_WIDTH-1:0]  ctr, div;
    logic [1:0]            phase;
    logic [BW-1:0]         bit_idx;
    logic [FRAME_BITS:0]   tx;
    logic [FRAME_BITS-1:0] rx;
    logic                  owned, accept, running, stall, tick, bit_end, last_bit;

    assign cmd_ready = state == IDLE || state == HOLD;
    assign accept    = cmd_valid && cmd_ready;
    assign running   = state == START || state == DATA || state == STOP;
    // a slave holding SCL low while we release it freezes the phase timer
    assign stall     = STRETCH_EN && running && phase[1] && scl_out && !scl_in;
    assign tick      = running && !stall && ctr == div;
    assign bit_end   = tick && phase == 2'd3;
    assign last_bit  = bit_idx == BW'(FRAME_BITS);
    assign busy      = owned;

    always_comb begin
        state_n = state;
        scl_out = 1'b1;
        sda_out = 1'b1;
        case (state)
            IDLE: if (accept && cmd_op == 2'd0) state_n = START;
            HOLD: begin
                scl_out = 1'b0;
                if (accept) state_n = cmd_op == 2'd0 ? START : cmd_op == 2'd3 ? STOP : DATA;
            end
            START: begin
                scl_out = phase == 2'd1 || phase == 2'd2;
                sda_out = ~phase[1];
                if (bit_end) state_n = HOLD;
            end
            DATA: begin
                scl_out = phase[1];
                sda_out = tx[FRAME_BITS];
                if (bit_end && last_bit) state_n = HOLD;
            end
            STOP: begin
                scl_out = phase != 2'd0;
                sda_out = phase[1];
                if (bit_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ctr       <= '0;
            div       <= '0;
            phase     <= '0;
            bit_idx   <= '0;
            tx        <= '1;
            rx        <= '0;
            owned     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_nack  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            rsp_valid <= 1'b0;
            if (accept) begin
                div     <= clock_divisor;
                ctr     <= '0;
                phase   <= '0;
                bit_idx <= '0;
                // READ releases SDA for data and drives the ACK; WRITE releases SDA for the ACK
                tx      <= cmd_op == 2'd2 ? {{FRAME_BITS{1'b1}}, cmd_nack} : {cmd_data, 1'b1};
                if (state == IDLE && cmd_op[0] != cmd_op[1]) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_data  <= '0;
                    rsp_nack  <= 1'b1;
                end
            end else if (running && !stall) begin
                ctr <= tick ? '0 : ctr + DIV_WIDTH'(1);
                if (tick) phase <= phase + 2'd1;
            end
            if (bit_end && state == DATA) begin
                if (last_bit) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= rx;
                    rsp_nack  <= sda_in;
                end else begin
                    bit_idx <= bit_idx + BW'(1);
                    tx      <= {tx[FRAME_BITS-1:0], 1'b1};
                    rx      <= (rx << 1) | FRAME_BITS'(sda_in);
                end
            end
            if (bit_end && state == START) owned <= 1'b1;
            if (bit_end && state == STOP) owned <= 1'b0;
        end
    end
endmodule

// File: tb/tb_i2c_frame_master.sv
// tb_i2c_frame_master: table-driven vectors plus stretch and mid-frame reset sequences.
// A second instance with stretching disabled runs in lockstep for the stretch comparison.
module tb_i2c_frame_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] clock_divisor = 16'd3;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_nack = 1'b0;
    logic        slave_sda = 1'b1;
    logic        slave_scl = 1'b1;

    logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, scl_out, sda_out, scl_in, sda_in, busy;
    logic [7:0] rsp_data;
    logic       cmd_ready2, rsp_valid2, rsp_nack2, rsp_err2, scl_out2, sda_out2, scl_in2, sda_in2, busy2;
    logic [7:0] rsp_data2;

    int vectors = 0;
    int miscompares = 0;

    assign scl_in  = scl_out & slave_scl;
    assign sda_in  = sda_out & slave_sda;
    assign scl_in2 = scl_out2;
    assign sda_in2 = sda_out2 & slave_sda;

    always #5 clk = ~clk;

    i2c_frame_master #(.DIV_WIDTH(16), .FRAME_BITS(8), .STRETCH_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .clock_divisor(clock_divisor),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack), .rsp_err(rsp_err),
        .scl_out(scl_out), .sda_out(sda_out), .scl_in(scl_in), .sda_in(sda_in), .busy(busy)
    );

    i2c_frame_master #(.DIV_WIDTH(16), .FRAME_BITS(8), .STRETCH_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .clock_divisor(clock_divisor),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_nack(rsp_nack2), .rsp_err(rsp_err2),
        .scl_out(scl_out2), .sda_out(sda_out2), .scl_in(scl_in2), .sda_in(sda_in2), .busy(busy2)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] div;
        logic [7:0]  data;
        logic        nack;
        logic [7:0]  slave;
        logic        slave_ack;
        int          exp_n;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_nack;
        logic        exp_err;
        logic        exp_busy;
        logic        exp_scl;
        logic        exp_sda;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // issue one command, mimic the slave, check every phase start, then the completion
    task automatic apply(input vec_t v);
        int n, len, b, k, j;
        logic ec, es;
        clock_divisor = v.div;
        cmd_op        = v.op;
        cmd_data      = v.data;
        cmd_nack      = v.nack;
        cmd_valid     = 1'b1;
        check("cmd_ready before accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid     = 1'b0;
        clock_divisor = v.div ^ 16'h0005;
        n   = 0;
        len = 4 * (int'(v.div) + 1);
        while (!(rsp_valid || cmd_ready) && n < 2000) begin
            b = n / len;
            k = n % len;
            j = k / (int'(v.div) + 1);
            slave_sda = (v.op == 2'd2 && b < 8) ? v.slave[7-b] : (v.op == 2'd1 && b == 8) ? v.slave_ack : 1'b1;
            case (v.op)
                2'd0:    begin ec = j == 1 || j == 2; es = j < 2; end
                2'd3:    begin ec = j != 0; es = j >= 2; end
                2'd1:    begin ec = j >= 2; es = b < 8 ? v.data[7-b] : 1'b1; end
                default: begin ec = j >= 2; es = b < 8 ? 1'b1 : v.nack; end
            endcase
            if (k % (int'(v.div) + 1) == 0) begin
                check("scl phase", 32'(scl_out), 32'(ec));
                check("sda phase", 32'(sda_out), 32'(es));
            end
            step();
            n++;
        end
        slave_sda = 1'b1;
        check("latency", 32'(n), 32'(v.exp_n));
        check("rsp_valid", 32'(rsp_valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            check("rsp_data", 32'(rsp_data), 32'(v.exp_data));
            check("rsp_nack", 32'(rsp_nack), 32'(v.exp_nack));
            check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        end
        check("busy", 32'(busy), 32'(v.exp_busy));
        check("scl after", 32'(scl_out), 32'(v.exp_scl));
        check("sda after", 32'(sda_out), 32'(v.exp_sda));
        step();
        check("rsp_valid pulse width", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int t1, t2, seen;
        vec_t start3, stop3;
        //             op    div    data   nk  slave  ack  n    vld data   nk  err  bsy scl sda
        vecs[0]  = '{2'd0, 16'd3, 8'h00, 0, 8'h00, 1, 16,  0, 8'h00, 0, 0, 1, 0, 1};
        vecs[1]  = '{2'd1, 16'd3, 8'hA5, 0, 8'h00, 0, 144, 1, 8'hA5, 0, 0, 1, 0, 1};
        vecs[2]  = '{2'd2, 16'd3, 8'h00, 1, 8'h3C, 1, 144, 1, 8'h3C, 1, 0, 1, 0, 1};
        vecs[3]  = '{2'd2, 16'd3, 8'h00, 0, 8'h81, 1, 144, 1, 8'h81, 0, 0, 1, 0, 1};
        vecs[4]  = '{2'd1, 16'd2, 8'h00, 0, 8'h00, 1, 108, 1, 8'h00, 1, 0, 1, 0, 1};
        vecs[5]  = '{2'd0, 16'd1, 8'h00, 0, 8'h00, 1, 8,   0, 8'h00, 0, 0, 1, 0, 1};
        vecs[6]  = '{2'd3, 16'd3, 8'h00, 0, 8'h00, 1, 16,  0, 8'h00, 0, 0, 0, 1, 1};
        vecs[7]  = '{2'd1, 16'd3, 8'h5A, 0, 8'h00, 1, 0,   1, 8'h00, 1, 1, 0, 1, 1};
        vecs[8]  = '{2'd2, 16'd3, 8'h00, 1, 8'h00, 1, 0,   1, 8'h00, 1, 1, 0, 1, 1};
        vecs[9]  = '{2'd3, 16'd3, 8'h00, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 0, 1, 1};
        vecs[10] = '{2'd0, 16'd0, 8'h00, 0, 8'h00, 1, 4,   0, 8'h00, 0, 0, 1, 0, 1};
        vecs[11] = '{2'd1, 16'd0, 8'h5A, 0, 8'h00, 0, 36,  1, 8'h5A, 0, 0, 1, 0, 1};
        vecs[12] = '{2'd3, 16'd0, 8'h00, 0, 8'h00, 1, 4,   0, 8'h00, 0, 0, 0, 1, 1};
        start3 = vecs[0];
        stop3  = vecs[6];

        repeat (3) step();
        check("reset scl", 32'(scl_out), 32'd1);
        check("reset sda", 32'(sda_out), 32'd1);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        check("reset rsp_nack", 32'(rsp_nack), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) apply(vecs[i]);

        // stretch: slave holds SCL low for 20 cycles from bit 3 p2
        apply(start3);
        clock_divisor = 16'd3;
        cmd_op        = 2'd1;
        cmd_data      = 8'hFF;
        cmd_valid     = 1'b1;
        step();
        cmd_valid = 1'b0;
        t1 = -1;
        t2 = -1;
        for (int n = 0; n < 400 && (t1 < 0 || t2 < 0); n++) begin
            slave_scl = !(n >= 56 && n < 76);
            if (rsp_valid && t1 < 0) t1 = n;
            if (rsp_valid2 && t2 < 0) t2 = n;
            step();
        end
        slave_scl = 1'b1;
        check("stretched frame latency", 32'(t1), 32'd164);
        check("unstretched frame latency", 32'(t2), 32'd144);
        apply(stop3);

        // reset in bit 5 of a WRITE
        apply(start3);
        clock_divisor = 16'd3;
        cmd_op        = 2'd1;
        cmd_data      = 8'h00;
        cmd_valid     = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (80) step();
        check("bit 5 scl low before reset", 32'(scl_out), 32'd0);
        rst = 1'b1;
        #1;
        check("async reset scl", 32'(scl_out), 32'd1);
        check("async reset sda", 32'(sda_out), 32'd1);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        rst  = 1'b0;
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            if (rsp_valid) seen++;
            step();
        end
        check("no response after reset", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
